instr_byte_tx: RTL and testbench

Instruction byte transmitter: accepts whole instructions (3-bit opcode + 13-bit address) through a valid/ready handshake and buffers them in a small FIFO. It serializes each instruction onto the 8-bit data bus as two bytes, high byte first, with a write strobe and a wait-stated grant. It is used to program instruction memory and to source the CPU's two-byte instruction fetch format. Byte 0 is {OPCODE[2:0], ADDR[12:8]}; byte 1 is ADDR[7:0].

---
 rtl/instr_byte_tx_pkg.sv | 22 ++
 rtl/instr_byte_tx_fifo.sv | 46 ++++
 rtl/instr_byte_tx.sv | 82 ++++++++
 tb/tb_instr_byte_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_byte_tx_pkg.sv
// instr_pkg: instruction word layout, transmitter states and byte-split helpers
// shared by the transmit side and any receive-side reassembly logic.
package instr_pkg;
    localparam int OPCODE_W = 3;
    localparam int ADDR_W   = 13;
    localparam int BYTE_W   = 8;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [ADDR_W-1:0]   addr;
    } instr_t;

    typedef enum logic [1:0] {IDLE, HI, LO} tx_state_t;

    function automatic logic [BYTE_W-1:0] hi_byte(input instr_t i);
        return {i.opcode, i.addr[ADDR_W-1:BYTE_W]};
    endfunction

    function automatic logic [BYTE_W-1:0] lo_byte(input instr_t i);
        return i.addr[BYTE_W-1:0];
    endfunction
endpackage

// File: rtl/instr_byte_tx_fifo.sv
// instr_fifo: synchronous instruction FIFO; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module instr_fifo
    import instr_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          CLK_CTRL,
    input  logic          RESET,
    input  logic          i_push,
    input  instr_t        i_data,
    input  logic          i_pop,
    output instr_t        o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);
    instr_t      r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_wr_en;

    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_full  = o_count == (AW+1)'(DEPTH);
    assign o_empty = o_count == '0;
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_wr_en = i_push && !o_full;

    always_ff @(posedge CLK_CTRL) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop && !o_empty)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK_CTRL) begin
        if (w_wr_en)
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/instr_byte_tx.sv
// instr_byte_tx: buffers instructions and writes each one to memory as two bytes
// (high byte first) with a wait-stated grant and an auto-incrementing address.
module instr_byte_tx
    import instr_pkg::*;
#(
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 13'h0000
) (
    input  logic                CLK_CTRL,
    input  logic                RESET,
    input  logic                INSTR_VALID,
    output logic                INSTR_READY,
    input  logic [OPCODE_W-1:0] OPCODE,
    input  logic [ADDR_W-1:0]   ADDR_IR,
    input  logic                ADDR_LOAD,
    input  logic [ADDR_W-1:0]   ADDR_IN,
    input  logic                BUS_GRANT,
    output logic [BYTE_W-1:0]   DATA_BUS,
    output logic                DATA_OE,
    output logic                WR,
    output logic [ADDR_W-1:0]   MEM_ADDR,
    output logic                BYTE_PHASE,
    output logic                BUSY
);
    localparam int AW = $clog2(FIFO_DEPTH);

    tx_state_t         r_state;
    tx_state_t         w_next;
    logic [ADDR_W-1:0] r_mem_addr;
    instr_t            w_head;
    logic              w_full;
    logic              w_empty;
    logic [AW:0]       w_count;
    logic              w_push;
    logic              w_pop;

    assign INSTR_READY = !w_full && !RESET;
    assign w_push      = INSTR_VALID && INSTR_READY;
    assign w_pop       = r_state == LO && BUS_GRANT;

    instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK_CTRL (CLK_CTRL),
        .RESET    (RESET),
        .i_push   (w_push),
        .i_data   ({OPCODE, ADDR_IR}),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (w_count)
    );

    always_ff @(posedge CLK_CTRL) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_mem_addr <= BASE_ADDR;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && ADDR_LOAD)
                r_mem_addr <= ADDR_IN;
            else if (r_state != IDLE && BUS_GRANT)
                r_mem_addr <= r_mem_addr + 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        WR         = r_state != IDLE;
        DATA_OE    = r_state != IDLE;
        BYTE_PHASE = r_state == LO;
        MEM_ADDR   = r_mem_addr;
        BUSY       = r_state != IDLE || !w_empty;
        DATA_BUS   = r_state == HI ? hi_byte(w_head) : r_state == LO ? lo_byte(w_head) : '0;
        case (r_state)
            IDLE:    if (!w_empty) w_next = HI;
            HI:      if (BUS_GRANT) w_next = LO;
            // stay busy if anything remains after this pop, counting a same-cycle push
            LO:      if (BUS_GRANT) w_next = (w_count != (AW+1)'(1) || w_push) ? HI : IDLE;
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_instr_byte_tx.sv
// tb_instr_byte_tx: directed checks of the two-byte instruction writer plus a
// random-grant loopback through a simple two-byte receiver.
module tb_instr_byte_tx;
    logic        CLK_CTRL = 1'b0;
    logic        RESET = 1'b1;
    logic        INSTR_VALID = 1'b0;
    logic        INSTR_READY;
    logic [2:0]  OPCODE = '0;
    logic [12:0] ADDR_IR = '0;
    logic        ADDR_LOAD = 1'b0;
    logic [12:0] ADDR_IN = '0;
    logic        BUS_GRANT = 1'b1;
    logic [7:0]  DATA_BUS;
    logic        DATA_OE;
    logic        WR;
    logic [12:0] MEM_ADDR;
    logic        BYTE_PHASE;
    logic        BUSY;

    int n_checks = 0;
    int n_fail = 0;
    int g_mode = 0;
    int wr_idx;
    int gtab [7] = '{0, 0, 0, 1, 0, 0, 1};
    logic [7:0]  q_data [$];
    logic [12:0] q_addr [$];
    int          q_cyc [$];
    logic [15:0] rx [$];

    instr_byte_tx dut (
        .CLK_CTRL    (CLK_CTRL),
        .RESET       (RESET),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .OPCODE      (OPCODE),
        .ADDR_IR     (ADDR_IR),
        .ADDR_LOAD   (ADDR_LOAD),
        .ADDR_IN     (ADDR_IN),
        .BUS_GRANT   (BUS_GRANT),
        .DATA_BUS    (DATA_BUS),
        .DATA_OE     (DATA_OE),
        .WR          (WR),
        .MEM_ADDR    (MEM_ADDR),
        .BYTE_PHASE  (BYTE_PHASE),
        .BUSY        (BUSY)
    );

    always #5 CLK_CTRL = ~CLK_CTRL;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        INSTR_VALID = 1'b0;
        ADDR_LOAD = 1'b0;
        BUS_GRANT = 1'b1;
        @(negedge CLK_CTRL);
        @(negedge CLK_CTRL);
        check_eq("rst_ready", INSTR_READY, 0);
        check_eq("rst_wr", {DATA_OE, WR}, 0);
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_addr", MEM_ADDR, 0);
        check_eq("rst_data", DATA_BUS, 0);
        RESET = 1'b0;
        @(negedge CLK_CTRL);
        check_eq("rst_ready_after", INSTR_READY, 1);
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [15:0] w, output int waited);
        {OPCODE, ADDR_IR} = w;
        INSTR_VALID = 1'b1;
        waited = 0;
        while (!INSTR_READY && waited < 50) begin
            @(negedge CLK_CTRL);
            waited++;
        end
        if (waited == 50) check_eq("push_timeout", waited, 0);
        @(negedge CLK_CTRL);
        INSTR_VALID = 1'b0;
    endtask

    task automatic collect(input int n);
        logic       g;
        logic       rx_ph;
        logic [7:0] rx_hi;
        q_data.delete();
        q_addr.delete();
        q_cyc.delete();
        rx.delete();
        wr_idx = 0;
        rx_ph = 1'b0;
        rx_hi = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge CLK_CTRL);
            g = g_mode == 0 ? 1'b1 : g_mode == 1 ? (wr_idx < 7 ? gtab[wr_idx][0] : 1'b1) : 1'($urandom_range(0, 1));
            BUS_GRANT = g;
            if (WR) begin
                q_data.push_back(DATA_BUS);
                q_addr.push_back(MEM_ADDR);
                q_cyc.push_back(c);
                wr_idx++;
                if (g) begin
                    if (!rx_ph) rx_hi = DATA_BUS;
                    else rx.push_back({rx_hi, DATA_BUS});
                    rx_ph = !rx_ph;
                end
            end
        end
        BUS_GRANT = 1'b1;
    endtask

    initial begin
        int          w;
        logic [7:0]  exp_d [7];
        logic [12:0] exp_a [7];
        logic [15:0] lb [6];

        // single instruction, grant always high
        do_reset();
        push(16'hB234, w);
        check_eq("t1_idle_wr", WR, 0);
        check_eq("t1_idle_busy", BUSY, 1);
        @(negedge CLK_CTRL);
        check_eq("t1_hi_wr", {DATA_OE, WR, BYTE_PHASE}, 3'b110);
        check_eq("t1_hi_data", DATA_BUS, 8'hB2);
        check_eq("t1_hi_addr", MEM_ADDR, 0);
        @(negedge CLK_CTRL);
        check_eq("t1_lo_phase", BYTE_PHASE, 1);
        check_eq("t1_lo_data", DATA_BUS, 8'h34);
        check_eq("t1_lo_addr", MEM_ADDR, 1);
        @(negedge CLK_CTRL);
        check_eq("t1_end_wr", {WR, BUSY, BYTE_PHASE}, 0);
        check_eq("t1_end_addr", MEM_ADDR, 2);
        check_eq("t1_end_data", DATA_BUS, 0);

        // three back-to-back pushes into a 2-deep FIFO
        do_reset();
        g_mode = 0;
        exp_d = '{8'h2A, 8'hBC, 8'hDF, 8'h00, 8'h61, 8'h55, 8'h00};
        fork
            begin
                push(16'h2ABC, w);
                push(16'hDF00, w);
                push(16'h6155, w);
                check_eq("t2_stall_cycles", w, 2);
            end
            collect(14);
        join
        check_eq("t2_wr_count", q_data.size(), 6);
        if (q_cyc.size() == 6) check_eq("t2_contiguous", q_cyc[5] - q_cyc[0], 5);
        for (int i = 0; i < q_data.size() && i < 6; i++) begin
            check_eq($sformatf("t2_data%0d", i), q_data[i], exp_d[i]);
            check_eq($sformatf("t2_addr%0d", i), q_addr[i], i);
        end

        // wait states: 3 in HI, 2 in LO
        do_reset();
        g_mode = 1;
        exp_d = '{8'hB2, 8'hB2, 8'hB2, 8'hB2, 8'h34, 8'h34, 8'h34};
        exp_a = '{13'd0, 13'd0, 13'd0, 13'd0, 13'd1, 13'd1, 13'd1};
        fork
            push(16'hB234, w);
            collect(16);
        join
        check_eq("t3_wr_count", q_data.size(), 7);
        for (int i = 0; i < q_data.size() && i < 7; i++) begin
            check_eq($sformatf("t3_data%0d", i), q_data[i], exp_d[i]);
            check_eq($sformatf("t3_addr%0d", i), q_addr[i], exp_a[i]);
        end
        check_eq("t3_final_addr", MEM_ADDR, 2);
        g_mode = 0;

        // ADDR_LOAD in IDLE on the same edge as IDLE->HI, wrap, load ignored in LO
        do_reset();
        push(16'h4ACE, w);
        ADDR_LOAD = 1'b1;
        ADDR_IN = 13'h1FFF;
        @(negedge CLK_CTRL);
        ADDR_LOAD = 1'b0;
        check_eq("t4_hi_data", DATA_BUS, 8'h4A);
        check_eq("t4_hi_addr", MEM_ADDR, 13'h1FFF);
        @(negedge CLK_CTRL);
        check_eq("t4_lo_data", DATA_BUS, 8'hCE);
        check_eq("t4_lo_wrap", MEM_ADDR, 13'h0000);
        ADDR_LOAD = 1'b1;
        ADDR_IN = 13'h0777;
        @(negedge CLK_CTRL);
        ADDR_LOAD = 1'b0;
        check_eq("t4_load_ignored", MEM_ADDR, 13'h0001);
        check_eq("t4_idle_wr", WR, 0);

        // reset during LO with a second instruction queued
        do_reset();
        push(16'hB234, w);
        push(16'h6155, w);
        check_eq("t5_hi_wr", {WR, BYTE_PHASE}, 2'b10);
        @(negedge CLK_CTRL);
        check_eq("t5_lo_phase", BYTE_PHASE, 1);
        RESET = 1'b1;
        @(negedge CLK_CTRL);
        check_eq("t5_rst_wr", WR, 0);
        check_eq("t5_rst_ready", INSTR_READY, 0);
        check_eq("t5_rst_busy", BUSY, 0);
        check_eq("t5_rst_addr", MEM_ADDR, 0);
        check_eq("t5_rst_data", DATA_BUS, 0);
        RESET = 1'b0;
        @(negedge CLK_CTRL);
        check_eq("t5_ready_after", INSTR_READY, 1);
        check_eq("t5_empty_after", {WR, BUSY}, 0);
        @(negedge CLK_CTRL);
        check_eq("t5_no_lo_byte", WR, 0);

        // loopback with random grants
        do_reset();
        g_mode = 2;
        lb = '{16'hB234, 16'h2ABC, 16'hDF00, 16'h6155, 16'hFFFF, 16'h0001};
        fork
            begin
                for (int i = 0; i < 6; i++) push(lb[i], w);
            end
            collect(150);
        join
        g_mode = 0;
        check_eq("t6_rx_count", rx.size(), 6);
        for (int i = 0; i < rx.size() && i < 6; i++)
            check_eq($sformatf("t6_rx%0d", i), rx[i], lb[i]);
        check_eq("t6_final_addr", MEM_ADDR, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
